// File: rtl/vga_if.sv
// Pixel request / colour return and registered DAC-side outputs of the VGA timing generator.
// master = timing generator, slave = colour stage plus DAC.
interface vga_if;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_req;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        rgb_valid;
  logic        frame_start;

  modport master (
    input  pix_data,
    output pix_x, pix_y, pix_req, hsync, vsync, rgb, rgb_valid, frame_start
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, pix_req, hsync, vsync, rgb, rgb_valid, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pix_x/pix_y requested one clock ahead, colour and syncs registered together.
// Latency pix_x/pix_y -> rgb is 1 clock; free-running, no backpressure (pix_data must answer combinationally).
module vga_timing_gen #(
  parameter logic [9:0] H_SYNC   = 10'd96,
  parameter logic [9:0] H_BACK   = 10'd48,
  parameter logic [9:0] H_VALID  = 10'd640,
  parameter logic [9:0] H_FRONT  = 10'd16,
  parameter logic [9:0] V_SYNC   = 10'd2,
  parameter logic [9:0] V_BACK   = 10'd33,
  parameter logic [9:0] V_VALID  = 10'd480,
  parameter logic [9:0] V_FRONT  = 10'd10,
  parameter logic       SYNC_POL = 1'b0
) (
  input  logic  vga_clk,
  input  logic  sys_rst_n,
  vga_if.master vga
);

  localparam logic [9:0] H_TOTAL  = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam logic [9:0] V_TOTAL  = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam logic [9:0] HS       = H_SYNC + H_BACK;
  localparam logic [9:0] VS       = V_SYNC + V_BACK;
  // Request window leads the visible window by one clock horizontally.
  localparam logic [9:0] H_REQ_LO = HS - 10'd1;
  localparam logic [9:0] H_REQ_HI = HS + H_VALID - 10'd2;
  localparam logic [9:0] V_REQ_HI = VS + V_VALID - 10'd1;

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       pix_req;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_TOTAL - 10'd1) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_TOTAL - 10'd1) ? 10'd0 : cnt_v + 10'd1;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  assign pix_req = (cnt_h >= H_REQ_LO) && (cnt_h <= H_REQ_HI) &&
                   (cnt_v >= VS)       && (cnt_v <= V_REQ_HI);

  assign vga.pix_req = pix_req;
  assign vga.pix_x   = pix_req ? (cnt_h - H_REQ_LO) : 10'h3FF;
  assign vga.pix_y   = pix_req ? (cnt_v - VS)       : 10'h3FF;

  // pix_data is only looked at inside the request window so X from the colour stage never leaks.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vga.rgb         <= '0;
      vga.rgb_valid   <= 1'b0;
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.frame_start <= 1'b0;
    end else begin
      vga.rgb         <= pix_req ? vga.pix_data : 16'h0000;
      vga.rgb_valid   <= pix_req;
      vga.hsync       <= (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga.vsync       <= (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga.frame_start <= (cnt_h == 10'd0) && (cnt_v == 10'd0);
    end
  end

endmodule
